// File: rtl/store_buf_pkg.sv
// Shared types and constants for the posted-write store buffer.
// Forwarding is enabled by defining STORE_BUF_FWD_EN.
package store_buf_pkg;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } entry_t;

  function automatic logic [XLEN-3:0] word_adr(input logic [XLEN-1:0] a);
    return a[XLEN-1:2];
  endfunction

endpackage

// File: rtl/store_buf_match.sv
// Load-address lookup over the live store entries; youngest match wins.
// Only instantiated when STORE_BUF_FWD_EN is defined.
module store_buf_match
  import store_buf_pkg::*;
(
  input  entry_t            i_entries [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [XLEN-1:0]   i_adr,
  output logic              o_hit,
  output logic [XLEN-1:0]   o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // walk oldest to youngest so a later match overrides an earlier one
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < i_count) &&
          (word_adr(i_entries[i_head + PTR_W'(i)].addr) == word_adr(i_adr))) begin
        o_hit  = 1'b1;
        o_data = i_entries[i_head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and data memory.
// Define STORE_BUF_FWD_EN for store-to-load forwarding; otherwise loads stall until drained.
module store_buffer
  import store_buf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] DataAdr,
  input  logic [XLEN-1:0] WriteData,
  input  logic            LoadReq,
  output logic            StoreStall,
  output logic            LoadHit,
  output logic [XLEN-1:0] LoadData,
  output logic            LoadStall,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  entry_t           r_buf [DEPTH];

  logic w_push;
  logic w_pop;

  // full is taken from the registered count so mem_ready never reaches StoreStall
  assign StoreStall = (r_count == CNT_W'(DEPTH));
  assign mem_we     = (r_count != '0);
  assign w_push     = MemWrite && !StoreStall;
  assign w_pop      = mem_we && mem_ready;
  assign mem_addr   = mem_we ? r_buf[r_head].addr : '0;
  assign mem_wdata  = mem_we ? r_buf[r_head].data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_tail] <= '{addr: DataAdr, data: WriteData};
  end

`ifdef STORE_BUF_FWD_EN
  logic            w_hit;
  logic [XLEN-1:0] w_fwd_data;

  store_buf_match u_match (
    .i_entries (r_buf),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_adr     (DataAdr),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  assign LoadHit   = LoadReq && w_hit;
  assign LoadData  = LoadHit ? w_fwd_data : '0;
  assign LoadStall = 1'b0;
`else
  assign LoadHit   = 1'b0;
  assign LoadData  = '0;
  assign LoadStall = LoadReq && mem_we;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a driver records accepted stores in a queue,
// a negedge monitor compares the memory port and load outputs against that queue.
module tb_store_buffer;
  import store_buf_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            MemWrite = 1'b0;
  logic [XLEN-1:0] DataAdr = '0;
  logic [XLEN-1:0] WriteData = '0;
  logic            LoadReq = 1'b0;
  logic            mem_ready = 1'b0;
  logic            StoreStall, LoadHit, LoadStall, mem_we;
  logic [XLEN-1:0] LoadData, mem_addr, mem_wdata;

  store_buffer dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .LoadReq(LoadReq), .StoreStall(StoreStall),
    .LoadHit(LoadHit), .LoadData(LoadData), .LoadStall(LoadStall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t exp_q[$];
  st_t pend;
  bit  pend_v = 1'b0;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus; a store is accepted only if the buffer holds fewer than DEPTH entries
  task automatic cyc(input bit mw, input logic [31:0] adr, input logic [31:0] wd,
                     input bit lr, input bit rdy);
    @(posedge clk);
    if (pend_v) begin
      exp_q.push_back(pend);
      pend_v = 1'b0;
    end
    #1;
    MemWrite = mw; DataAdr = adr; WriteData = wd; LoadReq = lr; mem_ready = rdy;
    if (mw && exp_q.size() < DEPTH) begin
      pend.a = adr;
      pend.d = wd;
      pend_v = 1'b1;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_StoreStall"}, StoreStall, 0);
    chk({nm, "_LoadHit"},    LoadHit,    0);
    chk({nm, "_LoadData"},   LoadData,   0);
    chk({nm, "_LoadStall"},  LoadStall,  0);
    chk({nm, "_mem_we"},     mem_we,     0);
    chk({nm, "_mem_addr"},   mem_addr,   0);
    chk({nm, "_mem_wdata"},  mem_wdata,  0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bit          hit;
      logic [31:0] hd;
      hit = 1'b0;
      hd  = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (!hit && exp_q[i].a[31:2] == DataAdr[31:2]) begin
          hit = 1'b1;
          hd  = exp_q[i].d;
        end
      end
      chk("mem_we", mem_we, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("mem_addr",  mem_addr,  exp_q[0].a);
        chk("mem_wdata", mem_wdata, exp_q[0].d);
      end else begin
        chk("mem_addr_idle",  mem_addr,  0);
        chk("mem_wdata_idle", mem_wdata, 0);
      end
      chk("StoreStall", StoreStall, exp_q.size() == DEPTH);
`ifdef STORE_BUF_FWD_EN
      chk("LoadHit", LoadHit, LoadReq && hit);
      if (LoadReq && hit) chk("LoadData", LoadData, hd);
      chk("LoadStall", LoadStall, 0);
`else
      chk("LoadHit",   LoadHit,   0);
      chk("LoadData",  LoadData,  0);
      chk("LoadStall", LoadStall, LoadReq && exp_q.size() != 0);
`endif
      if (mem_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    int p_rdy;
    logic [31:0] adr;

    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    reset = 1'b1;

    // single store drains the next cycle
    cyc(1, 100, 25, 0, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 100);
    chk("t2_data", mem_wdata, 25);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t2_idle_we", mem_we, 0);

    // fill with memory stalled, overflow store ignored, drain in order
    for (int k = 0; k < 4; k++) cyc(1, 32'(4 * k), 32'(k + 1), 0, 0);
    cyc(1, 16, 99, 0, 0);
    @(negedge clk);
    chk("t3_full", StoreStall, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("t3_order", mem_addr, 32'(4 * k));
      chk("t3_stall", StoreStall, k == 0);
    end
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t3_empty", mem_we, 0);

    // younger store to the same word wins; stall policy without forwarding
    cyc(1, 96, 7, 0, 0);
    cyc(1, 96, 9, 0, 0);
    cyc(0, 96, 0, 1, 0);
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    chk("t4_hit96", LoadHit, 1);
    chk("t4_data96", LoadData, 9);
    cyc(0, 98, 0, 1, 0);
    @(negedge clk);
    chk("t4_hit98", LoadHit, 1);
    chk("t4_data98", LoadData, 9);
    cyc(0, 100, 0, 1, 0);
    @(negedge clk);
    chk("t4_miss100", LoadHit, 0);
`else
    chk("t5_lstall", LoadStall, 1);
`endif
    for (int k = 0; k < 3; k++) begin
      cyc(0, 96, 0, 1, 1);
      @(negedge clk);
`ifdef STORE_BUF_FWD_EN
      chk("t4_drain_hit", LoadHit, k < 2);
`else
      chk("t5_drain_stall", LoadStall, k < 2);
`endif
    end

    // full buffer with MemWrite and mem_ready together: pop only
    for (int k = 0; k < 4; k++) cyc(1, 32'(200 + 4 * k), 32'(k + 40), 0, 0);
    cyc(1, 300, 55, 0, 1);
    @(negedge clk);
    chk("t6_full", StoreStall, 1);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_notfull", StoreStall, 0);
    chk("t6_head", mem_addr, 204);
    repeat (4) cyc(0, 0, 0, 0, 1);

    // asynchronous reset with three stores pending
    for (int k = 0; k < 3; k++) cyc(1, 32'(400 + 4 * k), 32'(k + 70), 0, 0);
    cyc(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_zero("t1_rst");
    exp_q.delete();
    pend_v = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t1_no_write", mem_we, 0);

    // randomized traffic with varying memory back-pressure
    p_rdy = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) p_rdy = int'($urandom_range(10, 95));
      adr = ($urandom_range(0, 1) != 0) ? 32'h0000_0100 : 32'h8000_0100;
      adr = adr + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 99) < 60, adr, $urandom,
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < p_rdy);
    end
    repeat (DEPTH + 3) cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("final_drained", mem_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipelined RISC-V core's data-memory port (MemWrite / DataAdr / WriteData) and the data memory. Retired stores are absorbed in one cycle and drained in order to memory under a valid/ready handshake, so memory back-pressure does not stall the pipeline until the buffer fills. Loads probe the buffer so they never read memory contents older than a buffered store.

## Interface
- DEPTH, 4, number of store entries (power of two, 2..16)
- XLEN, 32, address/data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemWrite  in  1  core store request this cycle
- DataAdr  in  XLEN  store/load byte address from core
- WriteData  in  XLEN  store data from core
- LoadReq  in  1  core load request this cycle (uses DataAdr)
- StoreStall  out  1  buffer full; core must hold its store
- LoadHit  out  1  load address matches a buffered store
- LoadData  out  XLEN  forwarded data on LoadHit
- LoadStall  out  1  load must wait (see Configuration)
- mem_we  out  1  head entry valid toward memory
- mem_addr  out  XLEN  head entry address
- mem_wdata  out  XLEN  head entry data
- mem_ready  in  1  memory accepts head entry this cycle

## Operation
- Circular FIFO: head pointer, tail pointer, count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Push: MemWrite && !StoreStall writes {DataAdr, WriteData} at tail; tail++.
- Pop: mem_we && mem_ready; head++.
- Push and pop same cycle: both happen, count unchanged.
- StoreStall = (count == DEPTH), from registered count only; a same-cycle pop does not admit a push when full.
- MemWrite while StoreStall: ignored, no state change.
- mem_we = (count != 0); mem_addr/mem_wdata driven from head entry (combinational from registers).
- Word stores only; address match compares DataAdr[XLEN-1:2] against entry address [XLEN-1:2].
- Load lookup is combinational over valid entries; youngest matching entry wins (priority from tail-1 backward to head).
- Entry being popped in the current cycle still counts as valid for lookup that cycle.
- Store in the same cycle as a load to the same address is not visible to that load (push is registered).
- Reset (asynchronous, mid-drain included): head=tail=count=0; all entries discarded, not written to memory; outputs: StoreStall=0, LoadHit=0, LoadData=0, LoadStall=0, mem_we=0, mem_addr=0, mem_wdata=0 (data outputs gated to 0 when empty).

## Timing
- Store at edge N appears on mem port at earliest after edge N (visible cycle N+1).
- Drain throughput: one store per cycle with mem_ready held high.
- mem_addr/mem_wdata stable while mem_we=1 and mem_ready=0.
- StoreStall deasserts the cycle after the first pop from full.
- No combinational path from mem_ready to StoreStall; LoadHit/LoadData/LoadStall combinational from DataAdr and LoadReq.

## Configuration
- STORE_BUF_FWD_EN defined: forwarding active; LoadHit=LoadReq && match, LoadData=youngest match data, LoadStall=0.
- Undefined: no forwarding logic; LoadHit=0, LoadData=0, LoadStall=LoadReq && (count != 0) — load waits until buffer fully drained.

## Structure
- Package store_buf_pkg: entry type {addr, data}, DEPTH/pointer-width constants, word-address slice helper.
- Sub-module store_buf_match: priority match of load word address over entry array given head/count, outputs hit and data; instantiated only under STORE_BUF_FWD_EN.

## Test plan
- Reset low mid-operation with 3 entries -> all outputs 0, mem_we=0, no further memory writes after reset releases.
- mem_ready=1, store DataAdr=100 WriteData=25 -> next cycle mem_we=1, mem_addr=100, mem_wdata=25; following cycle mem_we=0.
- mem_ready=0, 4 stores (addr 0,4,8,12) -> StoreStall=1 after 4th; 5th store ignored; raise mem_ready -> writes drain in order 0,4,8,12, StoreStall drops after first pop.
- FWD_EN, stores 96<=7 then 96<=9 pending, LoadReq DataAdr=96 -> LoadHit=1, LoadData=9; DataAdr=98 -> same hit; DataAdr=100 -> LoadHit=0.
- Without FWD_EN, one pending entry, LoadReq -> LoadStall=1 until mem_ready pop, then 0.
- Full buffer, MemWrite and mem_ready both high -> one pop, no push, count DEPTH-1; wrap-around after 2*DEPTH stores keeps order.
